nexys_starship_btn_conditioner: RTL and testbench
=================================================

// Module: nexys_starship_btn_conditioner
// PURPOSE
//  Conditions the raw Nexys push-buttons (BtnC, BtnU, ...) before the game FSM uses them.
//  Per button: 2-FF synchroniser, then a debounce FSM.
//  Produces a debounced level, a single-cycle press pulse (SCEN) and an auto-repeat pulse (MCEN).
//  The game FSM consumes the SCEN outputs, so a single press advances it exactly once.
// PARAMETERS
//  NUM_BTN          5          number of independent button channels (bit i = button i)
//  DEBOUNCE_CYCLES  2500000    consecutive stable cycles required to accept press/release (>=2)
//  REPEAT_CYCLES    25000000   cycles between MCEN pulses while held (>=2)
// PORTS
//  Clk        in   1        system clock; all logic on posedge
//  Reset      in   1        asynchronous, active-low reset (0 = reset)
//  Btn_raw    in   NUM_BTN  raw asynchronous button inputs, 1 = pressed
//  Btn_db     out  NUM_BTN  debounced level, 1 while press accepted and release not yet accepted
//  Btn_scen   out  NUM_BTN  one-cycle pulse when a press is accepted
//  Btn_mcen   out  NUM_BTN  pulse on press acceptance, then every REPEAT_CYCLES while held
// BEHAVIOUR
//  - Reset low (async): all sync FFs, counters and outputs = 0; every FSM -> IDLE.
//    Reset is asynchronous on assert; outputs stay 0 until the first edge after Reset returns high.
//  - Sync: s = Btn_raw delayed 2 flops; the FSM sees only s.
//  - Counters: one per channel, width $clog2(max(DEBOUNCE_CYCLES,REPEAT_CYCLES))+1.
//    Counters saturate and never wrap.
//  - FSM per channel (one-hot or binary; states and transitions are fixed):
//    IDLE:    cnt=0; s=1 -> WAITP.
//    WAITP:   s=0 -> IDLE, cnt cleared.
//             s=1 -> cnt++.
//             cnt==DEBOUNCE_CYCLES-1 with s=1 -> PRESS.
//    PRESS:   one cycle only; Btn_scen[i]=Btn_mcen[i]=1 this cycle; cnt=0.
//             s=1 -> HOLD.
//             s=0 -> WAITR.
//    HOLD:    s=1 -> cnt++.
//             cnt==REPEAT_CYCLES-1 -> Btn_mcen[i]=1 for one cycle, cnt=0.
//             s=0 -> WAITR, cnt=0.
//    WAITR:   s=1 -> HOLD, cnt=0 (repeat timing restarts).
//             s=0 -> cnt++.
//             cnt==DEBOUNCE_CYCLES-1 with s=0 -> IDLE.
//  - Btn_db[i] = 1 in PRESS, HOLD and WAITR; 0 in IDLE and WAITP. Registered, not decoded combinationally.
//  - Btn_scen and Btn_mcen are registered, exactly one cycle wide, never asserted in back-to-back cycles.
//  - Latency: a clean edge on Btn_raw sampled at edge E0 gives Btn_scen high in the cycle after
//    edge E0+DEBOUNCE_CYCLES+2.
//  - Release latency to Btn_db=0 is the same.
//  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse and no level change.
//  - Channels are fully independent. Simultaneous presses give simultaneous pulses on each bit.
//  - Reset mid-debounce or mid-hold discards all progress. No pulse is emitted on reset release,
//    even if the button is held: the press must be re-qualified from IDLE.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, NUM_BTN=2)
//  1. Reset=0 with Btn_raw=2'b11 for 5 cycles -> all outputs 0.
//     Release reset, hold buttons -> Btn_scen pulses exactly once per bit, 6 edges after first sample.
//  2. Btn_raw[0] high for 3 cycles, then low -> Btn_db, Btn_scen, Btn_mcen stay 0 throughout.
//  3. Btn_raw[0] bounces 1,0,1,0 then steady 1 for 40 cycles -> exactly one Btn_scen[0].
//     Btn_mcen[0] at acceptance, then every 8 cycles (4 more pulses); Btn_db[0]=1.
//  4. While held, drop Btn_raw[0] for 2 cycles -> Btn_db[0] stays 1, no extra Btn_scen.
//     Next Btn_mcen[0] comes 8 cycles after the return to HOLD.
//  5. Press bit0 and bit1 on the same edge -> Btn_scen=2'b11 in one cycle.
//     Release bit1 only -> Btn_db=2'b01 six edges later.
//  6. Assert Reset while in HOLD -> outputs 0 immediately (async, no clock).
//     Deassert with button held -> the next Btn_scen comes only after full re-debounce.

Source files
------------

// File: rtl/nexys_starship_btn_conditioner.sv
// nexys_starship_btn_conditioner
//   Conditions raw Nexys push-buttons for the game FSM. Each button gets its
//   own channel: a 2-FF synchroniser followed by a debounce FSM that produces
//   a debounced level, a single-cycle press pulse and an auto-repeat pulse.
//
// Ports
//   Clk       in   1        system clock, posedge
//   Reset     in   1        asynchronous active-low reset
//   Btn_raw   in   NUM_BTN  raw button inputs, 1 = pressed
//   Btn_db    out  NUM_BTN  debounced level
//   Btn_scen  out  NUM_BTN  one-cycle pulse on press acceptance
//   Btn_mcen  out  NUM_BTN  pulse on acceptance, then every REPEAT_CYCLES held

// One button channel: synchroniser + debounce/repeat FSM.
module nexys_starship_btn_chan #(
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int CW              = 26
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic db,
    output logic scen,
    output logic mcen
);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WAITP, PRESS, HOLD, WAITR} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    sync_pipe;
    logic          s;
    logic [CW-1:0] cnt_inc;

    assign s = sync_pipe[1];
    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_pipe <= '0;
            state     <= IDLE;
            cnt       <= '0;
            db        <= 1'b0;
            scen      <= 1'b0;
            mcen      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], raw};
            // Pulses default low so each one is exactly one cycle wide.
            scen <= 1'b0;
            mcen <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    db  <= 1'b0;
                    if (s) state <= WAITP;
                end
                WAITP: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= PRESS;
                        cnt   <= '0;
                        scen  <= 1'b1;
                        mcen  <= 1'b1;
                        db    <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PRESS: begin
                    // Repeat interval starts counting from HOLD entry.
                    cnt   <= '0;
                    state <= s ? HOLD : WAITR;
                end
                HOLD: begin
                    if (!s) begin
                        state <= WAITR;
                        cnt   <= '0;
                    end else if (cnt == REP_LAST) begin
                        mcen <= 1'b1;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAITR: begin
                    if (s) begin
                        // Release bounce: return to HOLD with a fresh repeat interval.
                        state <= HOLD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        db    <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    db    <= 1'b0;
                end
            endcase
        end
    end
endmodule

module nexys_starship_btn_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] Btn_raw,
    output logic [NUM_BTN-1:0] Btn_db,
    output logic [NUM_BTN-1:0] Btn_scen,
    output logic [NUM_BTN-1:0] Btn_mcen
);
    localparam int MAXC = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        nexys_starship_btn_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .CW             (CW)
        ) u_chan (
            .Clk  (Clk),
            .Reset(Reset),
            .raw  (Btn_raw[i]),
            .db   (Btn_db[i]),
            .scen (Btn_scen[i]),
            .mcen (Btn_mcen[i])
        );
    end
endmodule

// File: tb/tb_nexys_starship_btn_conditioner.sv
// Directed bench for nexys_starship_btn_conditioner (NUM_BTN=2, debounce 4,
// repeat 8). Stimulus pushes expected pulse events (cycle, scen, mcen, db);
// a monitor pops and compares whenever any pulse output is high.
// Timing rule used below: input driven at negedge after edge c is seen by the
// FSM at edge c+3, so a press is accepted (pulse visible) after edge c+7.
module tb_nexys_starship_btn_conditioner;
    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] Btn_raw;
    logic [1:0] Btn_db, Btn_scen, Btn_mcen;

    typedef struct {
        int         cyc;
        logic [1:0] scen;
        logic [1:0] mcen;
        logic [1:0] db;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    nexys_starship_btn_conditioner #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Btn_raw (Btn_raw),
        .Btn_db  (Btn_db),
        .Btn_scen(Btn_scen),
        .Btn_mcen(Btn_mcen)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the next expected event exactly.
    always @(negedge Clk) begin
        if ((Btn_scen | Btn_mcen) != 2'b00) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse cyc=%0d got scen=%b mcen=%b db=%b, want no pulse",
                         cyc, Btn_scen, Btn_mcen, Btn_db);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.scen != Btn_scen || e.mcen != Btn_mcen || e.db != Btn_db) begin
                    n_err++;
                    $display("FAIL pulse got cyc=%0d scen=%b mcen=%b db=%b, want cyc=%0d scen=%b mcen=%b db=%b",
                             cyc, Btn_scen, Btn_mcen, Btn_db, e.cyc, e.scen, e.mcen, e.db);
                end
            end
        end
    end

    task automatic expect_ev(input int c, input logic [1:0] sc, input logic [1:0] mc, input logic [1:0] d);
        exp_t e;
        e.cyc = c; e.scen = sc; e.mcen = mc; e.db = d;
        q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            Btn_raw = v;
            @(negedge Clk);
        end
    endtask

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    int c;

    initial begin
        // 1: reset held with buttons pressed, then release with buttons held
        Reset   = 1'b0;
        Btn_raw = 2'b11;
        repeat (5) @(negedge Clk);
        chk("rst_db",   Btn_db,   2'b00);
        chk("rst_scen", Btn_scen, 2'b00);
        chk("rst_mcen", Btn_mcen, 2'b00);
        c = cyc;
        Reset = 1'b1;
        expect_ev(c + 7, 2'b11, 2'b11, 2'b11);
        drive(2'b11, 9);
        chk("t1_db_held", Btn_db, 2'b11);
        drive(2'b11, 1);
        drive(2'b00, 12);
        chk("t1_db_released", Btn_db, 2'b00);

        // 2: short glitch on bit0 -> nothing
        drive(2'b01, 3);
        drive(2'b00, 3);
        chk("t2_db_mid", Btn_db, 2'b00);
        drive(2'b00, 7);
        chk("t2_db_end", Btn_db, 2'b00);

        // 3: bounce then steady hold; press + 4 repeats
        c = cyc;
        drive(2'b01, 1); drive(2'b00, 1); drive(2'b01, 1); drive(2'b00, 1);
        expect_ev(c + 11, 2'b01, 2'b01, 2'b01);
        expect_ev(c + 20, 2'b00, 2'b01, 2'b01);
        expect_ev(c + 28, 2'b00, 2'b01, 2'b01);
        expect_ev(c + 36, 2'b00, 2'b01, 2'b01);
        expect_ev(c + 44, 2'b00, 2'b01, 2'b01);
        drive(2'b01, 40);
        chk("t3_db_held", Btn_db, 2'b01);

        // 4: 2-cycle dropout while held; repeat restarts 8 cycles after HOLD re-entry
        drive(2'b01, 2);
        drive(2'b00, 2);
        expect_ev(c + 59, 2'b00, 2'b01, 2'b01);
        drive(2'b01, 3);
        chk("t4_db_dropout", Btn_db, 2'b01);
        drive(2'b01, 11);
        drive(2'b00, 12);
        chk("t4_db_released", Btn_db, 2'b00);

        // 5: simultaneous press, release bit1 only
        c = cyc;
        expect_ev(c + 7,  2'b11, 2'b11, 2'b11);
        expect_ev(c + 16, 2'b00, 2'b01, 2'b01);
        drive(2'b11, 9);
        drive(2'b01, 9);
        chk("t5_db_bit1_rel", Btn_db, 2'b01);
        drive(2'b00, 12);
        chk("t5_db_all_rel", Btn_db, 2'b00);

        // 6: async reset while in HOLD, then full re-qualification
        c = cyc;
        expect_ev(c + 7, 2'b01, 2'b01, 2'b01);
        drive(2'b01, 10);
        chk("t6_db_hold", Btn_db, 2'b01);
        #2 Reset = 1'b0;
        #1;
        chk("t6_async_db",   Btn_db,   2'b00);
        chk("t6_async_scen", Btn_scen, 2'b00);
        chk("t6_async_mcen", Btn_mcen, 2'b00);
        @(negedge Clk);
        drive(2'b01, 3);
        c = cyc;
        Reset = 1'b1;
        expect_ev(c + 7, 2'b01, 2'b01, 2'b01);
        drive(2'b01, 6);
        chk("t6_db_requal", Btn_db, 2'b00);
        drive(2'b01, 4);
        chk("t6_db_accepted", Btn_db, 2'b01);
        drive(2'b00, 12);

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL missing_pulses got %0d outstanding, want 0 (next cyc=%0d)", q.size(), q[0].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
